// File: rtl/fifo_read_ctrl_if.sv
// Read-side stream bundle: FIFO pop port plus the downstream valid/ready stream.
interface fifo_read_ctrl_if #(
  parameter int data_Size = 8
);
  logic                 fifo_Empty;
  logic [data_Size-1:0] read_Data;
  logic                 r_Inc;
  logic [data_Size-1:0] out_Data;
  logic                 out_Valid;
  logic                 out_Ready;

  // Controller side: pops the FIFO and sources the output stream.
  modport master (
    input  fifo_Empty,
    input  read_Data,
    input  out_Ready,
    output r_Inc,
    output out_Data,
    output out_Valid
  );

  // Environment side: the FIFO read port and the downstream consumer.
  modport slave (
    output fifo_Empty,
    output read_Data,
    output out_Ready,
    input  r_Inc,
    input  out_Data,
    input  out_Valid
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain consumer for the async FIFO: pops words into a 2-entry registered
// buffer and presents them on a valid/ready stream, counting delivered words.
module fifo_read_ctrl #(
  parameter int data_Size = 8,
  parameter int cnt_Size  = 16
) (
  input  logic                r_Clk,
  input  logic                r_Rst,
  fifo_read_ctrl_if.master    bus,
  input  logic                rd_En,
  output logic [cnt_Size-1:0] word_Count,
  output logic [1:0]          buf_Occ
);

  logic                 run_q;
  logic [1:0]           occ_q;
  logic [1:0]           occ_next;
  logic                 valid_q;
  logic [data_Size-1:0] head_q;
  logic [data_Size-1:0] tail_q;
  logic [cnt_Size-1:0]  count_q;
  logic                 push;
  logic                 pop;

  // Pops are decoded from registered occupancy only, so downstream ready never
  // reaches the FIFO pointer logic combinationally. run_q keeps r_Inc low while
  // reset is held and releases it on the first clock edge after reset drops.
  assign push = run_q & rd_En & ~bus.fifo_Empty & ~occ_q[1];
  assign pop  = valid_q & bus.out_Ready;

  assign bus.r_Inc     = push;
  assign bus.out_Data  = head_q;
  assign bus.out_Valid = valid_q;
  assign buf_Occ       = occ_q;
  assign word_Count    = count_q;

  // Next occupancy: push adds one, transfer removes one, both together cancel.
  always_comb begin
    occ_next = occ_q;
    if (push && !pop) begin
      occ_next = occ_q + 2'd1;
    end else if (pop && !push) begin
      occ_next = occ_q - 2'd1;
    end
  end

  // Reset-release flag so popping starts synchronously after reset deasserts.
  always_ff @(posedge r_Clk or posedge r_Rst) begin
    if (r_Rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Occupancy and registered valid; valid mirrors a non-empty buffer.
  always_ff @(posedge r_Clk or posedge r_Rst) begin
    if (r_Rst) begin
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_next;
      valid_q <= (occ_next != 2'd0);
    end
  end

  // Head holds the oldest word; it loads from the FIFO when the buffer is empty
  // (or passing through at occupancy 1) and from the tail when draining a pair.
  always_ff @(posedge r_Clk or posedge r_Rst) begin
    if (r_Rst) begin
      head_q <= '0;
    end else if (push && (occ_q == 2'd0 || (occ_q == 2'd1 && pop))) begin
      head_q <= bus.read_Data;
    end else if (pop && occ_q == 2'd2) begin
      head_q <= tail_q;
    end
  end

  // Tail only captures when a push lands behind a word that is being held.
  always_ff @(posedge r_Clk or posedge r_Rst) begin
    if (r_Rst) begin
      tail_q <= '0;
    end else if (push && !pop && occ_q == 2'd1) begin
      tail_q <= bus.read_Data;
    end
  end

  // Delivered-word counter, wrapping naturally at its width.
  always_ff @(posedge r_Clk or posedge r_Rst) begin
    if (r_Rst) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a small behavioural FIFO model.
module tb_fifo_read_ctrl;

  logic       r_Clk;
  logic       r_Rst;
  logic       rd_En;
  logic [3:0] word_Count;
  logic [1:0] buf_Occ;

  fifo_read_ctrl_if #(.data_Size(8)) bus ();

  fifo_read_ctrl #(.data_Size(8), .cnt_Size(4)) dut (
    .r_Clk      (r_Clk),
    .r_Rst      (r_Rst),
    .bus        (bus),
    .rd_En      (rd_En),
    .word_Count (word_Count),
    .buf_Occ    (buf_Occ)
  );

  logic [7:0] mem [0:63];
  int         wrPtr = 0;
  int         rdPtr = 0;
  logic       forceEmpty = 1'b0;

  int         errorCount = 0;
  int         checkCount = 0;
  int         incCount = 0;
  int         xferTotal = 0;
  int         cycleNum = 0;
  logic [7:0] xferQ [$];
  int         incCyc [$];
  int         xferCyc [$];

  assign bus.fifo_Empty = forceEmpty | (wrPtr == rdPtr);
  assign bus.read_Data  = mem[rdPtr % 64];

  initial begin
    r_Clk = 1'b0;
    forever #5 r_Clk = ~r_Clk;
  end

  // FIFO model read pointer: advances on each pop, clears with the shared reset.
  always @(posedge r_Clk or posedge r_Rst) begin
    if (r_Rst) rdPtr <= 0;
    else if (bus.r_Inc) rdPtr <= rdPtr + 1;
  end

  // Monitor on the falling edge: records pops and transfers that the next rising edge commits.
  always @(negedge r_Clk) begin
    cycleNum++;
    if (!r_Rst) begin
      if (bus.r_Inc) begin
        incCount++;
        incCyc.push_back(cycleNum);
      end
      if (bus.out_Valid && bus.out_Ready) begin
        xferQ.push_back(bus.out_Data);
        xferCyc.push_back(cycleNum);
        xferTotal++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ready);
    rd_En         = en;
    bus.out_Ready = ready;
  endtask

  task automatic stepCycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge r_Clk);
      #2;
    end
  endtask

  task automatic pushWord(input logic [7:0] d);
    mem[wrPtr % 64] = d;
    wrPtr++;
  endtask

  int incBase;
  int xBase;
  int maxOcc;
  int n;
  logic seen15, seen16, seen17;

  initial begin
    r_Rst = 1'b0;
    applyStimulus(1'b1, 1'b1);
    #1 r_Rst = 1'b1;
    pushWord(8'hA5);
    stepCycle(3);
    checkOutput("rst_rinc",  {31'd0, bus.r_Inc}, 32'd0);
    checkOutput("rst_valid", {31'd0, bus.out_Valid}, 32'd0);
    checkOutput("rst_data",  {24'd0, bus.out_Data}, 32'd0);
    checkOutput("rst_count", {28'd0, word_Count}, 32'd0);
    checkOutput("rst_occ",   {30'd0, buf_Occ}, 32'd0);

    // Single word 0xA5
    incBase = incCount;
    r_Rst = 1'b0;
    stepCycle(1);
    checkOutput("single_rinc1", {31'd0, bus.r_Inc}, 32'd1);
    stepCycle(1);
    checkOutput("single_rinc0", {31'd0, bus.r_Inc}, 32'd0);
    checkOutput("single_valid", {31'd0, bus.out_Valid}, 32'd1);
    checkOutput("single_data",  {24'd0, bus.out_Data}, 32'hA5);
    stepCycle(1);
    checkOutput("single_valid0", {31'd0, bus.out_Valid}, 32'd0);
    checkOutput("single_count",  {28'd0, word_Count}, 32'd1);
    checkOutput("single_incs",   incCount - incBase, 32'd1);

    // Full-rate burst 0x00..0x07
    incBase = incCount;
    xBase = xferQ.size();
    maxOcc = 0;
    for (int i = 0; i < 8; i++) pushWord(8'(i));
    for (int c = 0; c < 12; c++) begin
      stepCycle(1);
      if (int'(buf_Occ) > maxOcc) maxOcc = int'(buf_Occ);
    end
    checkOutput("burst_incs",  incCount - incBase, 32'd8);
    checkOutput("burst_xfers", xferQ.size() - xBase, 32'd8);
    if (incCount - incBase == 8 && xferQ.size() - xBase == 8) begin
      checkOutput("burst_inc_span",  incCyc[incBase+7] - incCyc[incBase], 32'd7);
      checkOutput("burst_xfer_span", xferCyc[xBase+7] - xferCyc[xBase], 32'd7);
      for (int i = 0; i < 8; i++) checkOutput("burst_order", {24'd0, xferQ[xBase+i]}, i);
    end
    checkOutput("burst_count", {28'd0, word_Count}, 32'd9);
    checkOutput("burst_maxocc", maxOcc, 32'd1);

    // Backpressure
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) pushWord(8'(i));
    stepCycle(5);
    checkOutput("bp_occ",   {30'd0, buf_Occ}, 32'd2);
    checkOutput("bp_rinc",  {31'd0, bus.r_Inc}, 32'd0);
    checkOutput("bp_valid", {31'd0, bus.out_Valid}, 32'd1);
    checkOutput("bp_data",  {24'd0, bus.out_Data}, 32'h00);
    checkOutput("bp_level", wrPtr - rdPtr, 32'd6);
    xBase = xferQ.size();
    applyStimulus(1'b1, 1'b1);
    stepCycle(12);
    checkOutput("bp_xfers", xferQ.size() - xBase, 32'd8);
    if (xferQ.size() - xBase == 8)
      for (int i = 0; i < 8; i++) checkOutput("bp_order", {24'd0, xferQ[xBase+i]}, i);
    checkOutput("bp_count", {28'd0, word_Count}, 32'd1);

    // Enable low: no pops, buffered words still drain
    applyStimulus(1'b1, 1'b0);
    pushWord(8'h10); pushWord(8'h11); pushWord(8'h12);
    stepCycle(4);
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("en_rinc_now", {31'd0, bus.r_Inc}, 32'd0);
    incBase = incCount;
    xBase = xferQ.size();
    stepCycle(4);
    checkOutput("en_incs",  incCount - incBase, 32'd0);
    checkOutput("en_rinc",  {31'd0, bus.r_Inc}, 32'd0);
    checkOutput("en_xfers", xferQ.size() - xBase, 32'd2);
    if (xferQ.size() - xBase == 2) begin
      checkOutput("en_d0", {24'd0, xferQ[xBase]}, 32'h10);
      checkOutput("en_d1", {24'd0, xferQ[xBase+1]}, 32'h11);
    end
    checkOutput("en_level", wrPtr - rdPtr, 32'd1);
    xBase = xferQ.size();
    applyStimulus(1'b1, 1'b1);
    stepCycle(4);
    checkOutput("en_last_xfers", xferQ.size() - xBase, 32'd1);
    if (xferQ.size() - xBase == 1) checkOutput("en_d2", {24'd0, xferQ[xBase]}, 32'h12);
    checkOutput("en_count", {28'd0, word_Count}, 32'd4);

    // Empty flag held with rd_En high
    forceEmpty = 1'b1;
    pushWord(8'h20); pushWord(8'h21);
    incBase = incCount;
    stepCycle(5);
    checkOutput("empty_incs", incCount - incBase, 32'd0);
    checkOutput("empty_rinc", {31'd0, bus.r_Inc}, 32'd0);
    checkOutput("empty_occ",  {30'd0, buf_Occ}, 32'd0);
    forceEmpty = 1'b0;
    xBase = xferQ.size();
    stepCycle(5);
    checkOutput("empty_xfers", xferQ.size() - xBase, 32'd2);
    if (xferQ.size() - xBase == 2) begin
      checkOutput("empty_d0", {24'd0, xferQ[xBase]}, 32'h20);
      checkOutput("empty_d1", {24'd0, xferQ[xBase+1]}, 32'h21);
    end
    checkOutput("empty_count", {28'd0, word_Count}, 32'd6);

    // Mid-stream reset with a full buffer
    applyStimulus(1'b1, 1'b0);
    pushWord(8'h30); pushWord(8'h31); pushWord(8'h32);
    stepCycle(4);
    checkOutput("mid_pre_occ", {30'd0, buf_Occ}, 32'd2);
    #1 r_Rst = 1'b1;
    wrPtr = 0;
    #1;
    checkOutput("mid_valid", {31'd0, bus.out_Valid}, 32'd0);
    checkOutput("mid_occ",   {30'd0, buf_Occ}, 32'd0);
    checkOutput("mid_data",  {24'd0, bus.out_Data}, 32'd0);
    checkOutput("mid_count", {28'd0, word_Count}, 32'd0);
    checkOutput("mid_rinc",  {31'd0, bus.r_Inc}, 32'd0);
    stepCycle(1);
    r_Rst = 1'b0;
    pushWord(8'h3C);
    applyStimulus(1'b1, 1'b1);
    xBase = xferQ.size();
    stepCycle(5);
    checkOutput("mid_xfers", xferQ.size() - xBase, 32'd1);
    if (xferQ.size() - xBase == 1) checkOutput("mid_first", {24'd0, xferQ[xBase]}, 32'h3C);
    checkOutput("mid_post_count", {28'd0, word_Count}, 32'd1);

    // Counter wrap with a 4-bit counter
    r_Rst = 1'b1;
    wrPtr = 0;
    stepCycle(1);
    r_Rst = 1'b0;
    for (int i = 0; i < 17; i++) pushWord(8'(8'h40 + i));
    xBase = xferTotal;
    seen15 = 1'b0; seen16 = 1'b0; seen17 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      stepCycle(1);
      n = xferTotal - xBase;
      if (n == 15 && !seen15) begin
        seen15 = 1'b1;
        checkOutput("wrap_15", {28'd0, word_Count}, 32'd15);
      end
      if (n == 16 && !seen16) begin
        seen16 = 1'b1;
        checkOutput("wrap_16", {28'd0, word_Count}, 32'd0);
      end
      if (n == 17 && !seen17) begin
        seen17 = 1'b1;
        checkOutput("wrap_17", {28'd0, word_Count}, 32'd1);
      end
    end
    checkOutput("wrap_reached", {31'd0, seen15 & seen16 & seen17}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain. It pops words from the FIFO by driving r_Inc while watching fifo_Empty. Popped words go into a 2-entry registered output buffer, which presents them downstream on a valid/ready stream. The block decouples downstream backpressure from the FIFO's combinational read port, sustains 1 word/cycle and counts delivered words.

Parameters:
data_Size, 8, width of FIFO words and of out_Data
cnt_Size, 16, width of the delivered-word counter word_Count

Ports:
r_Clk  input  1  read-domain clock; all state on rising edge
r_Rst  input  1  reset, asynchronous, active-high; the same reset that clears the FIFO read pointer
fifo_Empty  input  1  FIFO empty flag (read domain)
read_Data  input  data_Size  FIFO read port; combinational from the current read address, valid whenever fifo_Empty=0
r_Inc  output  1  pop strobe to FIFO; the read pointer advances at the r_Clk edge where r_Inc=1
rd_En  input  1  drain enable; 0 stops new pops but buffered words still drain
out_Data  output  data_Size  head-of-buffer word
out_Valid  output  1  out_Data holds a valid word
out_Ready  input  1  downstream accepts; a transfer occurs on any edge with out_Valid & out_Ready
word_Count  output  cnt_Size  number of transfers completed since reset, modulo 2^cnt_Size
buf_Occ  output  2  current buffer occupancy, 0..2

Behaviour:
- Reset (async assert, synchronous release): occupancy=0, out_Valid=0, out_Data=0, word_Count=0, r_Inc=0. Buffered words are discarded; the FIFO pointers clear on the same reset.
- r_Inc = rd_En & ~fifo_Empty & (buf_Occ < 2).
  - Decoded only from registered occupancy; no combinational path from out_Ready to r_Inc.
  - r_Inc is never 1 while fifo_Empty=1 (no underflow pop).
- push = r_Inc. On a push edge, read_Data is captured into the buffer tail.
- pop = out_Valid & out_Ready.
- Occupancy update per edge:
  - push only: +1
  - pop only: −1
  - push & pop: unchanged
  - Push with occupancy 2 cannot occur; pop with occupancy 0 cannot occur.
- Buffer is 2 registered entries (head/tail, or valid-bit skid pair).
  - out_Data is always the oldest word; strict FIFO order is preserved.
  - out_Valid = (buf_Occ != 0), registered.
- Latency: r_Inc=1 in cycle n → word on out_Data with out_Valid=1 in cycle n+1, provided the buffer was empty.
- Throughput: with out_Ready held 1 and the FIFO non-empty, occupancy stays at 1, giving one pop and one transfer every cycle.
- Backpressure:
  - While out_Valid=1 & out_Ready=0, out_Data and out_Valid are held stable.
  - The buffer fills to 2, then r_Inc drops to 0 until a transfer frees a slot; r_Inc may rise again on the cycle after that transfer.
- rd_En=0 forces r_Inc=0 in the same cycle. Buffered words remain and drain normally.
- fifo_Empty may lag true FIFO state by the synchroniser delay. The block relies only on empty being pessimistic; no words are lost or duplicated.
- word_Count increments by 1 on each transfer edge and wraps from 2^cnt_Size−1 to 0. It has no saturation.
- Reset mid-stream: all outputs return to reset values immediately (asynchronously); the first post-reset word appears as after power-up.

Test Plan:
- Reset: assert r_Rst with the FIFO holding data → r_Inc=0, out_Valid=0, out_Data=0, word_Count=0, buf_Occ=0 while reset is held.
- Single word: FIFO holds 0xA5, out_Ready=1, rd_En=1 → r_Inc=1 for exactly one cycle; next cycle out_Valid=1 with out_Data=0xA5 for one cycle; word_Count=1.
- Full-rate burst: 8 words 0x00..0x07, out_Ready=1 → 8 consecutive r_Inc cycles, then 8 consecutive transfers in order 0x00..0x07; word_Count=8; buf_Occ never exceeds 1.
- Backpressure: out_Ready=0 during the burst → buf_Occ reaches 2, r_Inc=0, out_Data stays at 0x00. On release, output continues 0x00,0x01,0x02... with no gaps or duplicates; the FIFO retains exactly 6 words.
- Enable/empty: rd_En=0 with the FIFO non-empty → r_Inc stays 0 and buffered words still drain. Separately, fifo_Empty=1 with rd_En=1 → r_Inc never asserts.
- Counter wrap: cnt_Size=4, deliver 17 words → word_Count reads 15 after 15 transfers, 0 after 16, 1 after 17.
- Mid-stream reset: pulse r_Rst with buf_Occ=2 → out_Valid=0 and buf_Occ=0 immediately. After release and refill with 0x3C, the first output is 0x3C.
